// File: rtl/sfp_accum.sv
// Special-function accumulate stage: sums L partial-sum vectors per output with
// signed saturating lanes, optional ReLU on the output, valid/ready result port.

module sfp_lane #(
    parameter int psum_bw = 16
) (
    input  logic               first_i,
    input  logic               relu_i,
    input  logic [psum_bw-1:0] acc_i,
    input  logic [psum_bw-1:0] in_i,
    output logic [psum_bw-1:0] res_o,
    output logic [psum_bw-1:0] out_o,
    output logic               clamp_o
);
    logic [psum_bw:0]   sum;
    logic [psum_bw-1:0] sat;
    logic               clamp;

    always_comb begin
        sum   = {acc_i[psum_bw-1], acc_i} + {in_i[psum_bw-1], in_i};
        sat   = sum[psum_bw-1:0];
        clamp = 1'b0;
        // Extended sign disagreeing with the top result bit means the add left range
        if (sum[psum_bw] != sum[psum_bw-1]) begin
            clamp = 1'b1;
            sat   = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end
        res_o   = first_i ? in_i : sat;
        clamp_o = ~first_i & clamp;
        out_o   = (relu_i && res_o[psum_bw-1]) ? '0 : res_o;
    end
endmodule

module sfp_accum #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int len_bw  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [len_bw-1:0]        cfg_len,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [col*psum_bw-1:0]   out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     ovf
);
    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    state_t                         state_q;
    logic [len_bw:0]                cnt_q, len_q, len_d;
    logic                           relu_q, ovf_q;
    logic [col-1:0][psum_bw-1:0]    acc_q, out_q;
    logic [col-1:0][psum_bw-1:0]    lane_res, lane_out;
    logic [col-1:0]                 lane_clamp;
    logic                           first, last;

    // cnt/len carry one extra bit so a length of 16 compares without wrapping
    assign len_d = (cfg_len == '0) ? {1'b1, {len_bw{1'b0}}} : {1'b0, cfg_len};
    assign first = (cnt_q == '0);
    assign last  = (cnt_q == len_q - 1'b1);

    for (genvar i = 0; i < col; i++) begin : g_lane
        sfp_lane #(.psum_bw(psum_bw)) u_lane (
            .first_i (first),
            .relu_i  (relu_q),
            .acc_i   (acc_q[i]),
            .in_i    (in_data[i*psum_bw +: psum_bw]),
            .res_o   (lane_res[i]),
            .out_o   (lane_out[i]),
            .clamp_o (lane_clamp[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            relu_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    len_q   <= len_d;
                    relu_q  <= cfg_relu;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= ACC;
                end
                ACC: if (in_valid) begin
                    acc_q <= lane_res;
                    cnt_q <= cnt_q + 1'b1;
                    if (|lane_clamp) ovf_q <= 1'b1;
                    if (last) begin
                        out_q   <= lane_out;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_sfp_accum.sv
// Directed bench for sfp_accum: inputs driven and outputs checked on the falling
// edge, expected vectors hand-computed.

module tb_sfp_accum;
    logic               clk = 1'b0;
    logic               reset, start, cfg_relu, in_valid, out_ready;
    logic [3:0]         cfg_len;
    logic [7:0][15:0]   vin;
    logic               in_ready, out_valid, busy, ovf;
    logic [127:0]       out_data;
    logic [7:0][15:0]   exp_v;
    int                 tests = 0, fails = 0;

    always #5 clk = ~clk;

    sfp_accum dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_data(vin), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .ovf(ovf)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; cfg_len = '0; cfg_relu = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; vin = '0;
        tick(); tick();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        reset = 1'b1;
        tick();

        // Basic sum: 100 - 30 + 5 = 75
        start = 1'b1; cfg_len = 4'd3; cfg_relu = 1'b0;
        tick();
        start = 1'b0;
        chk("b_in_ready", 128'(in_ready), 128'(1));
        chk("b_busy", 128'(busy), 128'(1));
        in_valid = 1'b1; vin = rep(16'd100);
        tick(); vin = rep(-16'sd30);
        tick(); vin = rep(16'd5);
        chk("b_no_early_valid", 128'(out_valid), 128'(0));
        tick(); in_valid = 1'b0;
        chk("b_out_valid", 128'(out_valid), 128'(1));
        chk("b_in_ready_drain", 128'(in_ready), 128'(0));
        chk("b_data", out_data, rep(16'd75));
        chk("b_ovf", 128'(ovf), 128'(0));
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        chk("b_valid_drop", 128'(out_valid), 128'(0));
        chk("b_idle", 128'(busy), 128'(0));

        // ReLU with mixed signs
        start = 1'b1; cfg_len = 4'd2; cfg_relu = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) vin[i] = 16'((i - 4) * 10);
        in_valid = 1'b1;
        tick(); tick(); in_valid = 1'b0;
        exp_v = '0; exp_v[5] = 16'd20; exp_v[6] = 16'd40; exp_v[7] = 16'd60;
        chk("r_valid", 128'(out_valid), 128'(1));
        chk("r_data", out_data, exp_v);
        chk("r_ovf", 128'(ovf), 128'(0));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Saturation both directions
        start = 1'b1; cfg_len = 4'd2; cfg_relu = 1'b0;
        tick(); start = 1'b0;
        vin = '0; vin[0] = 16'd30000; vin[1] = -16'sd30000; in_valid = 1'b1;
        tick(); vin[0] = 16'd10000; vin[1] = -16'sd10000;
        tick(); in_valid = 1'b0;
        exp_v = '0; exp_v[0] = 16'h7FFF; exp_v[1] = 16'h8000;
        chk("s_data", out_data, exp_v);
        chk("s_ovf", 128'(ovf), 128'(1));
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("s_ovf_sticky_idle", 128'(ovf), 128'(1));

        // Length 0 means 16, input toggling every cycle
        start = 1'b1; cfg_len = 4'd0;
        tick(); start = 1'b0;
        chk("h_ovf_cleared", 128'(ovf), 128'(0));
        vin = rep(16'd1);
        for (int k = 0; k < 31; k++) begin
            in_valid = (k % 2 == 0);
            tick();
            if (k == 29) chk("h_not_done_at_15", 128'(out_valid), 128'(0));
        end
        in_valid = 1'b0;
        chk("h_valid", 128'(out_valid), 128'(1));
        chk("h_data", out_data, rep(16'd16));
        // Backpressure: output must hold and start must be ignored
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; cfg_len = 4'd1; in_valid = 1'b1; vin = rep(16'd3);
            tick();
            chk("h_hold_valid", 128'(out_valid), 128'(1));
            chk("h_hold_data", out_data, rep(16'd16));
            chk("h_hold_in_ready", 128'(in_ready), 128'(0));
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        chk("h_release", 128'(out_valid), 128'(0));
        chk("h_idle_after", 128'(busy), 128'(0));

        // Reset mid-accumulation
        start = 1'b1; cfg_len = 4'd4; cfg_relu = 1'b0;
        tick(); start = 1'b0;
        vin = rep(16'd1234); in_valid = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("m_busy", 128'(busy), 128'(0));
        chk("m_in_ready", 128'(in_ready), 128'(0));
        chk("m_out_data", out_data, 128'(0));
        reset = 1'b1; in_valid = 1'b0;
        start = 1'b1; cfg_len = 4'd1;
        tick(); start = 1'b0;
        vin = rep(16'd7); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("m_valid", 128'(out_valid), 128'(1));
        chk("m_data", out_data, rep(16'd7));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Back-to-back L=1 vectors, cycle 0 is the first start cycle
        start = 1'b1; cfg_len = 4'd1; cfg_relu = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; vin = rep(16'd9);
        tick(); start = 1'b0;
        chk("bb_c1_ready", 128'(in_ready), 128'(1));
        chk("bb_c1_valid", 128'(out_valid), 128'(0));
        tick();
        chk("bb_c2_valid", 128'(out_valid), 128'(1));
        chk("bb_c2_data", out_data, rep(16'd9));
        vin = rep(-16'sd9);
        tick();
        chk("bb_c3_valid", 128'(out_valid), 128'(0));
        start = 1'b1;
        tick(); start = 1'b0;
        chk("bb_c4_ready", 128'(in_ready), 128'(1));
        tick();
        chk("bb_c5_valid", 128'(out_valid), 128'(1));
        chk("bb_c5_data", out_data, rep(16'hFFF7));
        in_valid = 1'b0;
        tick();
        chk("bb_c6_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
